// File: rtl/read_32bit_from_ip_ram.sv
// Reads four consecutive bytes from an 8-bit RAM and presents them as one 32-bit word.
// Byte order is little-endian unless RD_BIG_ENDIAN_EN is defined.
module read_32bit_from_ip_ram #(
    parameter int ADDR_WIDTH = 19,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [ADDR_WIDTH-1:0] ram_address,
    input  logic [7:0]            ram_readdata,
    output logic [31:0]           data_out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            issue_cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           shadow;
    logic [31:0]           assembled;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [1:0]            tag_idx [RD_LATENCY];
    logic                  emerge;
    logic                  last;

    function automatic logic [4:0] lane(input logic [1:0] i);
`ifdef RD_BIG_ENDIAN_EN
        return {~i, 3'b000};
`else
        return {i, 3'b000};
`endif
    endfunction

    assign emerge = tag_vld[RD_LATENCY-1];
    assign last   = emerge && (tag_idx[RD_LATENCY-1] == 2'd3);
    assign busy   = (state != IDLE);

    assign ram_address = (state == ISSUE)
                       ? base + ADDR_WIDTH'(issue_cnt)
                       : '0;

    // Shadow with the emerging byte merged in; data_out only ever sees a full word
    always_comb begin
        assembled = shadow;
        assembled[lane(tag_idx[RD_LATENCY-1]) +: 8] = ram_readdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            base      <= '0;
            shadow    <= '0;
            data_out  <= '0;
            done      <= 1'b0;
            tag_vld   <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            done       <= 1'b0;
            tag_vld[0] <= (state == ISSUE);
            tag_idx[0] <= issue_cnt;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end

            if (emerge) begin
                shadow <= assembled;
            end
            if (last) begin
                data_out <= assembled;
                done     <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (read_enable) begin
                        base      <= address;
                        issue_cnt <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    issue_cnt <= issue_cnt + 2'd1;
                    if (issue_cnt == 2'd3) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
